// File: rtl/mod3_pkg.sv
// rtl/mod3_pkg.sv - shared state encoding and mod-3 remainder transition table
package mod3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } tx_state_t;

  localparam logic [1:0] REM0 = 2'b00;
  localparam logic [1:0] REM1 = 2'b01;
  localparam logic [1:0] REM2 = 2'b10;

  // (2*r + b) mod 3; the detector uses this same table
  function automatic logic [1:0] rem_next(input logic [1:0] r, input logic b);
    case (r)
      REM0:    return b ? REM1 : REM0;
      REM1:    return b ? REM0 : REM2;
      REM2:    return b ? REM2 : REM1;
      default: return REM0;
    endcase
  endfunction

endpackage

// File: rtl/mod3_serial_tx_if.sv
// rtl/mod3_serial_tx_if.sv - word request and serial output bundle of the transmitter
interface mod3_serial_tx_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             outbit;
  logic             bit_valid;
  logic             busy;
  logic [1:0]       rem;
  logic             done;
  logic             divisible;

  modport master (
    output start, data_in,
    input  outbit, bit_valid, busy, rem, done, divisible
  );

  modport slave (
    input  start, data_in,
    output outbit, bit_valid, busy, rem, done, divisible
  );
endinterface

// File: rtl/mod3_serial_tx_tick_gen.sv
// rtl/mod3_serial_tx_tick_gen.sv - clock-enable tick, one pulse every TICK_DIV cycles
module bit_tick_gen #(
  parameter int TICK_DIV = 20000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/mod3_serial_tx.sv
// rtl/mod3_serial_tx.sv - MSB-first serial word transmitter with running mod-3 remainder
module mod3_serial_tx
  import mod3_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 20000000
) (
  input  logic                  clock,
  input  logic                  reset,
  mod3_serial_tx_if.slave       bus
);
  localparam int BW = $clog2(WIDTH);

  tx_state_t        state, state_nx;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]    bcnt;
  logic [1:0]       rem_q;
  logic             bit_valid_q;
  logic             divisible_q;
  logic             tick;
  logic             accept;

  assign accept = (state == IDLE) && bus.start;

  bit_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (accept),
    .tick  (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.outbit = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nx = SHIFT;
      end
      SHIFT: begin
        bus.busy   = 1'b1;
        bus.outbit = sreg[WIDTH-1];
        if (tick && bcnt == '0) state_nx = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // rem always reflects the bit currently on outbit, so it updates together with the shift
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sreg        <= '0;
      bcnt        <= '0;
      rem_q       <= REM0;
      bit_valid_q <= 1'b0;
      divisible_q <= 1'b0;
    end else begin
      bit_valid_q <= 1'b0;
      if (accept) begin
        sreg        <= bus.data_in;
        bcnt        <= BW'(WIDTH - 1);
        rem_q       <= rem_next(REM0, bus.data_in[WIDTH-1]);
        bit_valid_q <= 1'b1;
        divisible_q <= 1'b0;
      end else if (state == SHIFT && tick) begin
        if (bcnt != '0) begin
          sreg        <= sreg << 1;
          bcnt        <= bcnt - BW'(1);
          rem_q       <= rem_next(rem_q, sreg[WIDTH-2]);
          bit_valid_q <= 1'b1;
        end else begin
          divisible_q <= (rem_q == REM0);
        end
      end
    end
  end

  assign bus.bit_valid = bit_valid_q;
  assign bus.rem       = rem_q;
  assign bus.divisible = divisible_q;
endmodule
